// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct, runs single-cycle ops with a registered result,
// and multiplies on an iterative shift-add engine that stalls the pipe through ready_o.
module alu_exec_unit #(
  parameter int DATA_W = 32,
  parameter int BPC    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              illegal_o
);

  localparam int STEPS = DATA_W / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic {IDLE, MUL} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_ILL} op_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mcand_q, mcand_d;
  logic [DATA_W-1:0]  mplier_q, mplier_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               valid_q, valid_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  op_t                op;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W-1:0]  partial;
  logic [DATA_W-1:0]  acc_next;
  logic               accept;

  always_comb begin
    op = OP_ILL;
    unique case (ALUOp_i)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: op = OP_OR;
      default: begin
        case (funct_i)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b101010: op = OP_SLT;
          6'b011000: op = OP_MUL;
          default:   op = OP_ILL;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_SLT:  alu_res = ($signed(data1_i) < $signed(data2_i)) ? DATA_W'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  // Multiplicand times the low BPC multiplier bits, built from shifted copies.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  assign acc_next = acc_q + partial;
  assign ready_o  = (state_q == IDLE);
  assign accept   = valid_i && ready_o && !flush_i;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    zero_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = CNT_W'(STEPS);
            state_d  = MUL;
          end else begin
            result_d  = alu_res;
            valid_d   = 1'b1;
            zero_d    = (alu_res == '0);
            illegal_d = (op == OP_ILL);
          end
        end
      end
      MUL: begin
        // A flush abandons the product, even on the step that would deliver it.
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << BPC;
          mplier_d = mplier_q >> BPC;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = IDLE;
            result_d = acc_next;
            valid_d  = 1'b1;
            zero_d   = (acc_next == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected results,
// per-DUT monitors pop and compare whenever valid_o pulses.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         valid_i, flush_i, ready_o, valid_o, zero_o, illegal_o;
  logic [1:0]   ALUOp_i;
  logic [5:0]   funct_i;
  logic [W-1:0] data1_i, data2_i, result_o;

  logic         valid4, ready4, vout4, zero4, ill4;
  logic [W-1:0] a4, b4, res4;

  alu_exec_unit #(.DATA_W(W), .BPC(1)) dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
    .flush_i(flush_i), .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o),
    .illegal_o(illegal_o)
  );

  alu_exec_unit #(.DATA_W(W), .BPC(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid4), .ready_o(ready4),
    .ALUOp_i(2'b11), .funct_i(6'b011000), .data1_i(a4), .data2_i(b4),
    .flush_i(1'b0), .valid_o(vout4), .result_o(res4), .zero_o(zero4),
    .illegal_o(ill4)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_res;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic fl, input logic push,
                               input logic [W-1:0] res, input logic ill, input int lat);
    exp_t e;
    int waitc = 0;
    while (!ready_o && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!ready_o) checkOutput("ready_timeout", ready_o, 1);
    valid_i = 1'b1; ALUOp_i = op; funct_i = fn; data1_i = a; data2_i = b; flush_i = fl;
    if (push) begin
      e.res = res; e.zero = (res == '0); e.ill = ill; e.cyc = cyc + lat;
      sb.push_back(e);
      last_res = res;
    end
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic applyMul4(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res);
    exp_t e;
    int n = 0;
    while (!ready4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready4) checkOutput("ready4_timeout", ready4, 1);
    valid4 = 1'b1; a4 = a; b4 = b;
    e.res = res; e.zero = (res == '0); e.ill = 1'b0; e.cyc = cyc + 9;
    sb4.push_back(e);
    @(negedge clk);
    valid4 = 1'b0;
    n = 0;
    while (!ready4 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mul4_ready_low", n, 8);
  endtask

  always @(negedge clk) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid got result=%0h expected no valid_o", result_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result_o, e.res);
        checkOutput("zero", zero_o, e.zero);
        checkOutput("illegal", illegal_o, e.ill);
        checkOutput("latency_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (vout4) begin
      if (sb4.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid4 got result=%0h expected no valid_o", res4);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        checkOutput("result4", res4, e.res);
        checkOutput("zero4", zero4, e.zero);
        checkOutput("latency4_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ALUOp_i = '0; funct_i = '0;
    data1_i = '0; data2_i = '0; valid4 = 1'b0; a4 = '0; b4 = '0; last_res = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", ready_o, 1);
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_result", result_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(2'b11, 6'b100000, 32'd5, 32'd7, 1'b0, 1'b1, 32'd12, 1'b0, 1);
    checkOutput("ready_after_add", ready_o, 1);

    // Back-to-back single-cycle ops, one accepted per cycle.
    applyStimulus(2'b11, 6'b100010, 32'd9, 32'd9, 1'b0, 1'b1, 32'd0, 1'b0, 1);
    applyStimulus(2'b11, 6'b100101, 32'hF0, 32'h0F, 1'b0, 1'b1, 32'hFF, 1'b0, 1);
    applyStimulus(2'b11, 6'b101010, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'd1, 1'b0, 1);
    applyStimulus(2'b01, 6'b000000, 32'd3, 32'd3, 1'b0, 1'b1, 32'd0, 1'b0, 1);
    applyStimulus(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'd0, 1'b0, 1);
    applyStimulus(2'b10, 6'b000000, 32'h1234_0000, 32'h5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1);
    applyStimulus(2'b11, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b1, 32'h0F00_0F00, 1'b0, 1);
    applyStimulus(2'b11, 6'b101010, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 1'b0, 1);
    applyStimulus(2'b11, 6'b100010, 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1);
    @(negedge clk);

    applyStimulus(2'b11, 6'b011000, 32'd7, 32'd6, 1'b0, 1'b1, 32'd42, 1'b0, 33);
    n = 0;
    while (!ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("mul_ready_low", n, 32);
    applyStimulus(2'b11, 6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd1, 1'b0, 33);
    applyStimulus(2'b11, 6'b011000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 32'd0, 1'b0, 33);

    applyStimulus(2'b11, 6'b111111, 32'd4, 32'd5, 1'b0, 1'b1, 32'd0, 1'b1, 1);
    applyStimulus(2'b00, 6'b111111, 32'h10, 32'h20, 1'b0, 1'b1, 32'h30, 1'b0, 1);

    applyStimulus(2'b11, 6'b100000, 32'd1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b0, 1);
    checkOutput("flush_idle_valid", valid_o, 0);

    // Flush partway through a multiply.
    applyStimulus(2'b11, 6'b011000, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0, 33);
    repeat (8) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_mid_ready", ready_o, 1);
    checkOutput("flush_mid_valid", valid_o, 0);
    checkOutput("flush_mid_result", result_o, last_res);

    // Flush on the final multiply step suppresses the result.
    applyStimulus(2'b11, 6'b011000, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0, 33);
    repeat (31) @(negedge clk);
    checkOutput("flush_last_busy", ready_o, 0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_last_ready", ready_o, 1);
    checkOutput("flush_last_valid", valid_o, 0);
    checkOutput("flush_last_result", result_o, last_res);

    applyStimulus(2'b11, 6'b100000, 32'd2, 32'd3, 1'b0, 1'b1, 32'd5, 1'b0, 1);

    applyMul4(32'd7, 32'd6, 32'd42);
    applyMul4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    applyMul4(32'h1234_5678, 32'd9, 32'hA3D7_0A38);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(2'b11, 6'b011000, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0, 33);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", valid_o, 0);
    checkOutput("rst_mid_result", result_o, 0);
    checkOutput("rst_mid_zero", zero_o, 0);
    checkOutput("rst_mid_ready", ready_o, 1);
    checkOutput("rst_mid_result4", res4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(2'b01, 6'b000000, 32'd10, 32'd3, 1'b0, 1'b1, 32'd7, 1'b0, 1);

    n = 0;
    while ((sb.size() != 0 || sb4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", sb.size() + sb4.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
